// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory store controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DMEM_DATA_W  = 16;
    localparam int DMEM_ADDR_W  = 16;
    localparam int DMEM_TIMEOUT = 15;

endpackage

// File: rtl/dmem_write_ctrl_if.sv
// Data-memory write bus between the store controller (master) and memory (slave).
interface dmem_write_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_ack
    );
endinterface

// File: rtl/dmem_wr_buffer.sv
// Single-entry pending store buffer; load wins over take when both are raised.
module dmem_wr_buffer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              take,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_write_ctrl.sv
// Data-memory store controller: SETUP/STROBE/HOLD write cycle with ack/timeout,
// plus a one-deep pending buffer so a second store can be queued mid-write.
module dmem_write_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int TIMEOUT = DMEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] AR_out,
    input  logic [DATA_W-1:0] MDR_out,
    output logic              wr_ready,
    output logic              busy,
    output logic              wr_done,
    output logic              wr_err,
    output state_t            state_dbg,
    dmem_write_ctrl_if.master mem
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Handshake: a store is taken on any rising edge where dmem_write && wr_ready;
    // with wr_ready low the request is ignored and must be re-presented later.
    logic accept;

    state_t            state, next_state;
    logic [ADDR_W-1:0] active_addr;
    logic [DATA_W-1:0] active_data;
    logic [7:0]        cnt;
    logic              we_q, done_q, err_q;

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;

    logic load_new, load_pend, pend_load, pend_take;
    logic cnt_clr, cnt_inc, done_n, err_n;

    assign wr_ready = !pend_valid;
    assign accept   = dmem_write && wr_ready;
    assign busy     = (state != IDLE) || pend_valid;

    dmem_wr_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pend_load),
        .take      (pend_take),
        .load_addr (AR_out),
        .load_data (MDR_out),
        .valid     (pend_valid),
        .addr      (pend_addr),
        .data      (pend_data)
    );

    always_comb begin
        next_state = state;
        load_new   = 1'b0;
        load_pend  = 1'b0;
        pend_load  = 1'b0;
        pend_take  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_new   = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                cnt_clr    = 1'b1;
                pend_load  = accept;
                next_state = STROBE;
            end
            STROBE: begin
                pend_load = accept;
                // Ack takes precedence over a timeout landing on the same cycle.
                if (mem.mem_ack) begin
                    done_n     = 1'b1;
                    next_state = HOLD;
                end else if (cnt == CNT_LAST) begin
                    err_n      = 1'b1;
                    next_state = HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (pend_valid) begin
                    pend_take  = 1'b1;
                    load_pend  = 1'b1;
                    next_state = SETUP;
                end else if (accept) begin
                    load_new   = 1'b1;
                    next_state = SETUP;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            active_addr <= '0;
            active_data <= '0;
            cnt         <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state  <= next_state;
            we_q   <= (next_state == STROBE);
            done_q <= done_n;
            err_q  <= err_n;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 8'd1;
            end
            if (load_new) begin
                active_addr <= AR_out;
                active_data <= MDR_out;
            end else if (load_pend) begin
                active_addr <= pend_addr;
                active_data <= pend_data;
            end
        end
    end

    assign mem.mem_addr  = active_addr;
    assign mem.mem_wdata = active_data;
    assign mem.mem_we    = we_q;
    assign wr_done       = done_q;
    assign wr_err        = err_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_dmem_write_ctrl.sv
// Directed bench for dmem_write_ctrl: single store, wait states, timeout,
// back-to-back queuing, reset mid-write and stray acks.
module tb_dmem_write_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dmem_write = 1'b0;
    logic [15:0] AR_out = '0;
    logic [15:0] MDR_out = '0;
    logic        wr_ready, busy, wr_done, wr_err;
    state_t      state_dbg;

    logic        ack_en = 1'b0;
    logic        stray_ack = 1'b0;
    int          ack_delay = 0;
    int          we_run = 0;

    int n_checks = 0;
    int n_err = 0;

    dmem_write_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

    dmem_write_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_write (dmem_write),
        .AR_out     (AR_out),
        .MDR_out    (MDR_out),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .state_dbg  (state_dbg),
        .mem        (mem_bus.master)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after ack_delay strobe cycles.
    always @(posedge clk) begin
        if (mem_bus.mem_we) we_run <= we_run + 1;
        else                we_run <= 0;
    end
    assign mem_bus.mem_ack = stray_ack || (ack_en && mem_bus.mem_we && (we_run == ack_delay));

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_store(input logic [15:0] a, input logic [15:0] d);
        dmem_write = 1'b1;
        AR_out     = a;
        MDR_out    = d;
        tick();
        dmem_write = 1'b0;
    endtask

    task automatic run_count(input int max_cyc, output int we_c, output int done_c, output int err_c);
        logic idle_seen;
        we_c = 0; done_c = 0; err_c = 0; idle_seen = 1'b0;
        for (int i = 0; i < max_cyc && !idle_seen; i++) begin
            tick();
            if (mem_bus.mem_we) we_c++;
            if (wr_done)        done_c++;
            if (wr_err)         err_c++;
            if (!busy)          idle_seen = 1'b1;
        end
        chk("idle_reached", 32'(idle_seen), 32'd1);
    endtask

    int we_c, done_c, err_c;

    initial begin
        // Reset state
        #12;
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        chk("rst_we", 32'(mem_bus.mem_we), 32'd0);
        chk("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_bus.mem_wdata), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", {30'd0, wr_done, wr_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single store, ack in first STROBE
        ack_en = 1'b1; ack_delay = 0;
        start_store(16'h0040, 16'hBEEF);
        chk("s1_setup_state", 32'(state_dbg), 32'(SETUP));
        chk("s1_setup_we", 32'(mem_bus.mem_we), 32'd0);
        chk("s1_setup_addr", 32'(mem_bus.mem_addr), 32'h0040);
        chk("s1_setup_data", 32'(mem_bus.mem_wdata), 32'hBEEF);
        tick();
        chk("s1_strobe_state", 32'(state_dbg), 32'(STROBE));
        chk("s1_strobe_we", 32'(mem_bus.mem_we), 32'd1);
        chk("s1_strobe_addr", 32'(mem_bus.mem_addr), 32'h0040);
        tick();
        chk("s1_hold_state", 32'(state_dbg), 32'(HOLD));
        chk("s1_hold_done", 32'(wr_done), 32'd1);
        chk("s1_hold_err", 32'(wr_err), 32'd0);
        chk("s1_hold_we", 32'(mem_bus.mem_we), 32'd0);
        chk("s1_hold_data", 32'(mem_bus.mem_wdata), 32'hBEEF);
        tick();
        chk("s1_end_busy", 32'(busy), 32'd0);
        chk("s1_end_done", 32'(wr_done), 32'd0);
        chk("s1_end_state", 32'(state_dbg), 32'(IDLE));

        // Wait states: ack after 4 extra cycles
        ack_delay = 4;
        start_store(16'h0100, 16'h5A5A);
        run_count(40, we_c, done_c, err_c);
        chk("ws_we_cycles", 32'(we_c), 32'd5);
        chk("ws_done", 32'(done_c), 32'd1);
        chk("ws_err", 32'(err_c), 32'd0);

        // Timeout: no ack at all
        ack_en = 1'b0;
        start_store(16'h0101, 16'h0F0F);
        run_count(60, we_c, done_c, err_c);
        chk("to_we_cycles", 32'(we_c), 32'd15);
        chk("to_err", 32'(err_c), 32'd1);
        chk("to_done", 32'(done_c), 32'd0);

        // Back-to-back with a dropped third request
        ack_en = 1'b1; ack_delay = 1;
        start_store(16'h0010, 16'h1111);
        tick();
        chk("bb_strobe1", 32'(state_dbg), 32'(STROBE));
        dmem_write = 1'b1; AR_out = 16'h0011; MDR_out = 16'h2222;
        tick();
        chk("bb_ready_low", 32'(wr_ready), 32'd0);
        chk("bb_busy", 32'(busy), 32'd1);
        AR_out = 16'h0099; MDR_out = 16'h3333;
        tick();
        chk("bb_hold1", 32'(state_dbg), 32'(HOLD));
        chk("bb_done1", 32'(wr_done), 32'd1);
        chk("bb_hold1_addr", 32'(mem_bus.mem_addr), 32'h0010);
        tick();
        dmem_write = 1'b0;
        chk("bb_setup2", 32'(state_dbg), 32'(SETUP));
        chk("bb_setup2_addr", 32'(mem_bus.mem_addr), 32'h0011);
        chk("bb_setup2_data", 32'(mem_bus.mem_wdata), 32'h2222);
        chk("bb_ready_back", 32'(wr_ready), 32'd1);
        run_count(20, we_c, done_c, err_c);
        chk("bb_we2", 32'(we_c), 32'd2);
        chk("bb_done2", 32'(done_c), 32'd1);
        chk("bb_third_dropped", 32'(mem_bus.mem_addr), 32'h0011);

        // Reset mid-STROBE with a pending entry
        ack_en = 1'b0;
        dmem_write = 1'b1; AR_out = 16'h0200; MDR_out = 16'hAAAA;
        tick();
        AR_out = 16'h0201; MDR_out = 16'hBBBB;
        tick();
        dmem_write = 1'b0;
        chk("rs_strobe_we", 32'(mem_bus.mem_we), 32'd1);
        chk("rs_pending", 32'(wr_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async_we", 32'(mem_bus.mem_we), 32'd0);
        chk("rs_async_ready", 32'(wr_ready), 32'd1);
        chk("rs_async_busy", 32'(busy), 32'd0);
        chk("rs_async_addr", 32'(mem_bus.mem_addr), 32'd0);
        tick();
        chk("rs_no_pulse", {30'd0, wr_done, wr_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rs_idle", 32'(state_dbg), 32'(IDLE));
        ack_en = 1'b1; ack_delay = 0;
        start_store(16'h0300, 16'hC3C3);
        run_count(20, we_c, done_c, err_c);
        chk("rs_fresh_we", 32'(we_c), 32'd1);
        chk("rs_fresh_done", 32'(done_c), 32'd1);
        chk("rs_fresh_addr", 32'(mem_bus.mem_addr), 32'h0300);

        // Stray acks in IDLE and SETUP
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        chk("st_idle_state", 32'(state_dbg), 32'(IDLE));
        chk("st_idle_pulses", {30'd0, wr_done, wr_err}, 32'd0);
        chk("st_idle_busy", 32'(busy), 32'd0);
        ack_delay = 2;
        start_store(16'h0400, 16'h4444);
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        chk("st_setup_to_strobe", 32'(state_dbg), 32'(STROBE));
        chk("st_setup_pulses", {30'd0, wr_done, wr_err}, 32'd0);
        run_count(20, we_c, done_c, err_c);
        chk("st_we_rest", 32'(we_c), 32'd2);
        chk("st_done", 32'(done_c), 32'd1);
        chk("st_err", 32'(err_c), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
